// File: rtl/ddr_prbs_checker_ctrl_pkg.sv
// Shared types and PRBS-5 helpers for the DDR input throughput checker.
package ddr_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_CHECK,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int               LFSR_W      = 5;
   localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 5'b11111;

   typedef struct packed {
      logic              e0;
      logic              e1;
      logic [LFSR_W-1:0] nxt;
   } prbs_step_t;

   // Two XNOR steps at once: rise bit first, fall bit second.
   function automatic prbs_step_t prbs5_step2(input logic [LFSR_W-1:0] l);
      prbs_step_t s;
      s.e0  = ~(l[4] ^ l[2]);
      s.e1  = ~(l[3] ^ l[1]);
      s.nxt = {l[2:0], s.e0, s.e1};
      return s;
   endfunction

endpackage

// File: rtl/ddr_prbs_checker_ctrl_if.sv
// Control/sample/status bundle between the DDR capture stage, the checker and the status mux.
// err_inject exists only when DDR_ERR_INJECT_EN is defined.
interface ddr_prbs_checker_ctrl_if #(
   parameter int LEN_LOG2 = 8,
   parameter int CNT_W    = 10
);
   logic                start;
   logic                abort;
   logic                sample_en;
   logic                rise_bit;
   logic                fall_bit;
`ifdef DDR_ERR_INJECT_EN
   logic                err_inject;
`endif
   logic                busy;
   logic                locked;
   logic                done;
   logic                pass;
   logic [CNT_W-1:0]    err_cnt;
   logic [LEN_LOG2:0]   samp_cnt;

   modport master (
      output start, abort, sample_en, rise_bit, fall_bit,
`ifdef DDR_ERR_INJECT_EN
      output err_inject,
`endif
      input  busy, locked, done, pass, err_cnt, samp_cnt
   );

   modport slave (
      input  start, abort, sample_en, rise_bit, fall_bit,
`ifdef DDR_ERR_INJECT_EN
      input  err_inject,
`endif
      output busy, locked, done, pass, err_cnt, samp_cnt
   );
endinterface

// File: rtl/ddr_prbs_checker_ctrl_ref.sv
// PRBS-5 reference LFSR: shifts in received bit pairs while seeding,
// otherwise free-runs two steps per valid sample.
module ddr_prbs5_ref
   import ddr_test_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_en,
   input  logic              adv_en,
   input  logic [1:0]        seed_bits,
   output logic              e0,
   output logic              e1,
   output logic [LFSR_W-1:0] seed_val
);
   logic [LFSR_W-1:0] lfsr;
   prbs_step_t        step;

   assign step     = prbs5_step2(lfsr);
   assign e0       = step.e0;
   assign e1       = step.e1;
   assign seed_val = {lfsr[2:0], seed_bits};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       lfsr <= '0;
      else if (seed_en) lfsr <= seed_val;
      else if (adv_en)  lfsr <= step.nxt;
   end
endmodule

// File: rtl/ddr_prbs_checker_ctrl.sv
// DDR PRBS-5 throughput checker: seed, sync-check, count errors over a fixed window, hold result.
// Optional DDR_ERR_INJECT_EN adds err_inject, which flips the expected rise bit on RUN samples.
module ddr_prbs_checker_ctrl
   import ddr_test_pkg::*;
#(
   parameter int LEN_LOG2  = 8,
   parameter int CNT_W     = 10,
   parameter int SYNC_GOOD = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ddr_prbs_checker_ctrl_if.slave   bus
);
   localparam int                GOOD_W    = $clog2(SYNC_GOOD + 1);
   localparam int                RUN_LEN   = 1 << LEN_LOG2;
   localparam logic [LEN_LOG2:0] SAMP_LAST = (LEN_LOG2 + 1)'(RUN_LEN - 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(SYNC_GOOD - 1);

   state_t              state, state_nxt;
   logic [1:0]          seed_cnt, seed_cnt_nxt;
   logic [GOOD_W-1:0]   good_cnt, good_cnt_nxt;
   logic [CNT_W-1:0]    err_cnt;
   logic [LEN_LOG2:0]   samp_cnt;
   logic                seed_en, adv_en, clr_res, run_upd;
   logic                e0, e1, e0_exp, miss_r, miss_f;
   logic [LFSR_W-1:0]   seed_val;
   logic [CNT_W:0]      err_sum;
   logic [CNT_W-1:0]    err_nxt;

   ddr_prbs5_ref u_ref (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_en   (seed_en),
      .adv_en    (adv_en),
      .seed_bits ({bus.rise_bit, bus.fall_bit}),
      .e0        (e0),
      .e1        (e1),
      .seed_val  (seed_val)
   );

`ifdef DDR_ERR_INJECT_EN
   assign e0_exp = e0 ^ (bus.err_inject & (state == ST_RUN));
`else
   assign e0_exp = e0;
`endif
   assign miss_r  = bus.rise_bit ^ e0_exp;
   assign miss_f  = bus.fall_bit ^ e1;
   assign err_sum = {1'b0, err_cnt} + {{CNT_W{1'b0}}, miss_r} + {{CNT_W{1'b0}}, miss_f};
   assign err_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         seed_cnt <= '0;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         seed_cnt <= seed_cnt_nxt;
         good_cnt <= good_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      seed_cnt_nxt = seed_cnt;
      good_cnt_nxt = good_cnt;
      seed_en      = 1'b0;
      adv_en       = 1'b0;
      clr_res      = 1'b0;
      run_upd      = 1'b0;
      if (bus.abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_nxt    = ST_SEED;
                  seed_cnt_nxt = '0;
                  clr_res      = 1'b1;
               end
            end
            ST_SEED: begin
               if (bus.sample_en) begin
                  seed_en = 1'b1;
                  if (seed_cnt == 2'd2) begin
                     seed_cnt_nxt = '0;
                     // An all-ones seed would lock the XNOR LFSR; keep seeding.
                     if (seed_val != LFSR_LOCKUP) begin
                        state_nxt    = ST_CHECK;
                        good_cnt_nxt = '0;
                     end
                  end else begin
                     seed_cnt_nxt = seed_cnt + 2'd1;
                  end
               end
            end
            ST_CHECK: begin
               if (bus.sample_en) begin
                  adv_en = 1'b1;
                  if (miss_r | miss_f) begin
                     state_nxt    = ST_SEED;
                     seed_cnt_nxt = '0;
                     good_cnt_nxt = '0;
                  end else if (good_cnt == GOOD_LAST) begin
                     state_nxt = ST_RUN;
                  end else begin
                     good_cnt_nxt = good_cnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.sample_en) begin
                  adv_en  = 1'b1;
                  run_upd = 1'b1;
                  if (samp_cnt == SAMP_LAST) state_nxt = ST_DONE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt  <= '0;
         samp_cnt <= '0;
      end else if (clr_res) begin
         err_cnt  <= '0;
         samp_cnt <= '0;
      end else if (run_upd) begin
         err_cnt  <= err_nxt;
         samp_cnt <= samp_cnt + 1'b1;
      end
   end

   assign bus.busy     = (state == ST_SEED) || (state == ST_CHECK) || (state == ST_RUN);
   assign bus.locked   = (state == ST_RUN) || (state == ST_DONE);
   assign bus.done     = (state == ST_DONE);
   assign bus.pass     = (state == ST_DONE) && (err_cnt == '0);
   assign bus.err_cnt  = err_cnt;
   assign bus.samp_cnt = samp_cnt;
endmodule

// File: tb/tb_ddr_prbs_checker_ctrl.sv
// Randomized bench for ddr_prbs_checker_ctrl against a bit-history reference model;
// a second instance with a 3-bit error counter exercises saturation.
module tb_ddr_prbs_checker_ctrl;
   localparam int LEN_LOG2 = 8;
   localparam int RUN_LEN  = 1 << LEN_LOG2;
   localparam int MAX_L    = (1 << 10) - 1;
   localparam int MAX_S    = (1 << 3) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 0, abort = 0, se = 0, rb = 0, fb = 0, inj = 0;

   ddr_prbs_checker_ctrl_if #(.LEN_LOG2(LEN_LOG2), .CNT_W(10)) bus ();
   ddr_prbs_checker_ctrl_if #(.LEN_LOG2(LEN_LOG2), .CNT_W(3))  bus_s ();

   assign bus.start   = start;   assign bus_s.start   = start;
   assign bus.abort   = abort;   assign bus_s.abort   = abort;
   assign bus.sample_en = se;    assign bus_s.sample_en = se;
   assign bus.rise_bit = rb;     assign bus_s.rise_bit = rb;
   assign bus.fall_bit = fb;     assign bus_s.fall_bit = fb;
`ifdef DDR_ERR_INJECT_EN
   assign bus.err_inject = inj;  assign bus_s.err_inject = inj;
`endif

   ddr_prbs_checker_ctrl #(.LEN_LOG2(LEN_LOG2), .CNT_W(10), .SYNC_GOOD(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   ddr_prbs_checker_ctrl #(.LEN_LOG2(LEN_LOG2), .CNT_W(3), .SYNC_GOOD(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: mode 0 idle, 1 seed, 2 check, 3 run, 4 done; q holds the last 5 reference bits.
   int m_mode, m_err, m_err_s, m_samp, m_seedn, m_good;
   bit q[$];

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic qpush(input bit b);
      q.push_back(b);
      void'(q.pop_front());
   endtask

   function automatic bit pred();
      return ~(q[0] ^ q[2]);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_err = 0; m_err_s = 0; m_samp = 0; m_seedn = 0; m_good = 0;
      q = '{0, 0, 0, 0, 0};
   endtask

   task automatic model_step();
      bit p0, p1;
      int nerr;
      if (abort) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0, 4: if (start) begin
               m_mode = 1; m_err = 0; m_err_s = 0; m_samp = 0; m_seedn = 0;
            end
            1: if (se) begin
               qpush(rb); qpush(fb);
               m_seedn++;
               if (m_seedn == 3) begin
                  m_seedn = 0;
                  if (!(q[0] & q[1] & q[2] & q[3] & q[4])) begin m_mode = 2; m_good = 0; end
               end
            end
            2: if (se) begin
               p0 = pred(); qpush(p0);
               p1 = pred(); qpush(p1);
               if (rb != p0 || fb != p1) begin m_mode = 1; m_seedn = 0; m_good = 0; end
               else begin m_good++; if (m_good == 4) m_mode = 3; end
            end
            3: if (se) begin
               p0 = pred(); qpush(p0);
               p1 = pred(); qpush(p1);
`ifdef DDR_ERR_INJECT_EN
               nerr = int'(rb != (p0 ^ inj)) + int'(fb != p1);
`else
               nerr = int'(rb != p0) + int'(fb != p1);
`endif
               m_err   = sat(m_err + nerr, MAX_L);
               m_err_s = sat(m_err_s + nerr, MAX_S);
               m_samp++;
               if (m_samp == RUN_LEN) m_mode = 4;
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      chk("busy",     bus.busy,     m_mode inside {1, 2, 3});
      chk("locked",   bus.locked,   m_mode inside {3, 4});
      chk("done",     bus.done,     m_mode == 4);
      chk("pass",     bus.pass,     m_mode == 4 && m_err == 0);
      chk("err_cnt",  bus.err_cnt,  m_err);
      chk("samp_cnt", bus.samp_cnt, m_samp);
      chk("err_cnt_s", bus_s.err_cnt, m_err_s);
      chk("done_s",   bus_s.done,   m_mode == 4);
   endtask

   task automatic cyc(input bit st, input bit ab, input bit s_en, input bit r, input bit f, input bit ij);
      start = st; abort = ab; se = s_en; rb = r; fb = f; inj = ij;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Clean PRBS-5 source, restarted from 0 for each stream.
   logic [4:0] g;
   task automatic gen_pair(output bit r, output bit f);
      bit b;
      b = ~(g[4] ^ g[2]); g = {g[3:0], b}; r = b;
      b = ~(g[4] ^ g[2]); g = {g[3:0], b}; f = b;
   endtask

   // kind: 0 clean, 1 directed RUN errors, 2 CHECK error, 3 all RUN inverted, 4 inject, 5 random
   task automatic do_run(input int kind, input int budget);
      int lat, n, pos[5];
      bit r, f, s, st, ij, flag;
      lat = -1; n = 0; flag = 0;
      for (int k = 0; k < 5; k++) pos[k] = k * 50 + $urandom_range(0, 49);
      g = '0;
      cyc(1, 0, 1, 0, 0, 0);
      while (m_mode != 4 && n < budget) begin
         s  = (kind == 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
         r  = 1'($urandom); f = 1'($urandom);
         if (s) gen_pair(r, f);
         st = (kind == 5) && ($urandom_range(0, 15) == 0);
         ij = 0;
         if (s) begin
            case (kind)
               1: if (m_mode == 3) begin
                  if (m_samp == 10 || m_samp == 200) f = ~f;
                  if (m_samp == 50) begin r = ~r; f = ~f; end
               end
               2: if (m_mode == 2 && m_good == 2 && !flag) begin r = ~r; flag = 1; end
               3: if (m_mode == 3) begin r = ~r; f = ~f; end
               4: if (m_mode == 3) begin
                  for (int k = 0; k < 5; k++) if (m_samp == pos[k]) ij = 1;
               end
               5: if ($urandom_range(0, 63) == 0) r = ~r;
               default: ;
            endcase
         end
         cyc(st, 0, s, r, f, ij);
         n++;
         if (lat < 0 && bus.locked) lat = n;
      end
      chk("run_done", bus.done, 1);
      case (kind)
         0: begin
            chk("lock_lat", lat, 7);
            chk("clean_err", bus.err_cnt, 0);
            chk("clean_pass", bus.pass, 1);
            chk("clean_samp", bus.samp_cnt, RUN_LEN);
         end
         1: begin
            chk("dir_err", bus.err_cnt, 4);
            chk("dir_pass", bus.pass, 0);
            chk("dir_err_s", bus_s.err_cnt, 4);
         end
         2: begin
            chk("resync_lat", lat, 13);
            chk("resync_err", bus.err_cnt, 0);
         end
         3: begin
            chk("inv_err", bus.err_cnt, 2 * RUN_LEN);
            chk("inv_sat_s", bus_s.err_cnt, MAX_S);
         end
         4: chk("inj_err", bus.err_cnt, 5);
         default: ;
      endcase
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r, f;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk) rst_n = 1'b1;

      do_run(0, 400);
      do_run(1, 400);
      do_run(2, 400);
      do_run(3, 400);
`ifdef DDR_ERR_INJECT_EN
      do_run(4, 400);
`endif
      for (int i = 0; i < 3; i++) do_run(5, 3000);

      // Dead line stuck high: never leaves SEED, start ignored, abort exits.
      cyc(1, 0, 1, 1, 1, 0);
      for (int i = 0; i < 30; i++) cyc(i == 15, 0, 1, 1, 1, 0);
      chk("dead_busy", bus.busy, 1);
      chk("dead_locked", bus.locked, 0);
      cyc(0, 1, 1, 1, 1, 0);
      chk("dead_abort", bus.busy, 0);

      // Abort with start mid-RUN: abort wins, counters held.
      g = '0;
      cyc(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 100 && !(m_mode == 3 && m_samp == 20); i++) begin
         gen_pair(r, f); cyc(0, 0, 1, r, f, 0);
      end
      gen_pair(r, f);
      cyc(1, 1, 1, r, f, 0);
      chk("abort_samp", bus.samp_cnt, 20);
      chk("abort_done", bus.done, 0);
      chk("abort_busy", bus.busy, 0);

      // Asynchronous reset mid-RUN clears outputs without a clock edge.
      g = '0;
      cyc(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 100 && !(m_mode == 3 && m_samp == 50); i++) begin
         gen_pair(r, f); cyc(0, 0, 1, r, f, 0);
      end
      start = 0; abort = 0; se = 0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_samp", bus.samp_cnt, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clk) rst_n = 1'b1;
      do_run(0, 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ddr_prbs_checker_ctrl.md
Name: ddr_prbs_checker_ctrl

Overview:
- Sequences one DDR input throughput test run on the tile.
- Takes the rise/fall bit pair captured each clock from the DDR input stage and self-synchronises a local PRBS-5 reference.
- Counts bit errors over a fixed-length window and holds pass/fail status for readout on uo_out.
- Sits between the DDR capture flops and the output status mux.

Parameters:
- LEN_LOG2, 8, run window = 2^LEN_LOG2 valid samples (2 bits each).
- CNT_W, 10, error-counter width; counter saturates at all ones.
- SYNC_GOOD, 4, consecutive error-free samples required to declare lock.

Ports:
- clk  in  1  test clock; one DDR sample pair per rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE. Ignored while busy.
- abort  in  1  synchronous return to IDLE from any state.
- sample_en  in  1  rise_bit/fall_bit valid this cycle.
- rise_bit  in  1  bit captured on rising half; earlier in the sequence.
- fall_bit  in  1  bit captured on falling half; later in the sequence.
- busy  out  1  high in SEED, CHECK and RUN.
- locked  out  1  high in RUN and DONE when lock was achieved.
- done  out  1  high in DONE.
- pass  out  1  done and err_cnt==0.
- err_cnt  out  CNT_W  saturating bit-error count for the last run.
- samp_cnt  out  LEN_LOG2+1  valid samples consumed in RUN.

Behaviour:
- Reset values: all outputs 0, state IDLE, ref LFSR 5'd0.
- PRBS: shift-left XNOR LFSR with new bit = ~(l[4]^l[2]). Two steps per valid sample.
  - Expected rise bit: e0 = ~(l[4]^l[2]).
  - Expected fall bit: e1 = ~(l[3]^l[1]).
  - Next state: {l[2:0], e0, e1}.
- FSM states: IDLE, SEED, CHECK, RUN, DONE. The FSM advances only on sample_en, except for start and abort.
- IDLE: on start, go to SEED, clear err_cnt/samp_cnt, clear locked.
- SEED: each valid sample does lfsr <= {lfsr[2:0], rise_bit, fall_bit}. After 3 valid samples, go to CHECK.
  - If the seeded value is 5'b11111 (XNOR lockup, stuck-high line), stay in SEED and restart the 3-sample count.
- CHECK: compare inputs with e0/e1 and advance the LFSR.
  - Any mismatch: return to SEED; good count = 0.
  - SYNC_GOOD consecutive clean samples: go to RUN, set locked.
- RUN: compare each valid sample.
  - err_cnt += (rise^e0)+(fall^e1), i.e. 0..2, saturating at 2^CNT_W-1. A saturated value never wraps.
  - samp_cnt increments per valid sample.
  - On the sample that makes samp_cnt == 2^LEN_LOG2, go to DONE. That final sample's errors are included.
- DONE: hold all results. start goes to SEED (results cleared the same cycle).
- Latency: err_cnt/samp_cnt update one clock after the sample edge. done rises one clock after the final sample.
- Simultaneous events:
  - abort beats start.
  - abort in RUN returns to IDLE with err_cnt/samp_cnt held and done=0.
  - start while busy is ignored.
- No timeout in SEED/CHECK: a dead line keeps busy high until abort.
- Asynchronous reset mid-run: immediate return to the reset values.

Optional Feature:
- Macro: DDR_ERR_INJECT_EN.
- With the macro defined: extra input port err_inject (1 bit). When err_inject is high on a valid RUN sample, the expected rise bit e0 is inverted for that sample only. This adds exactly one error per injected sample and lets a loopback self-test the checker. Injection has no effect in SEED/CHECK.
- Without the macro: the port is absent and there is no comparator-path logic.

Decomposition:
- Shared package ddr_test_pkg holds:
  - state enum (IDLE/SEED/CHECK/RUN/DONE)
  - LFSR width constant 5
  - lockup constant 5'b11111
  - function prbs5_step2 returning {e0, e1, next_state}
- Sub-module ddr_prbs5_ref: 5-bit reference LFSR with seed-shift and two-step advance. The FSM and counters stay in the top.

Test Plan:
- Clean PRBS-5 stream from seed 0, sample_en=1, LEN_LOG2=8, start pulse:
  - lock after 3+4 samples
  - DONE 256 samples later
  - err_cnt=0, pass=1, samp_cnt=256
- Same stream with fall_bit inverted on RUN samples 10 and 200, plus both bits inverted on sample 50:
  - err_cnt=4, pass=0
- Inputs tied to 1: SEED loops on 5'b11111, busy stays 1, locked stays 0. abort returns to IDLE next cycle.
- Error injected in CHECK at clean sample 2: FSM returns to SEED, then locks on the next clean run. The final err_cnt excludes CHECK errors.
- CNT_W=3 with all RUN bits inverted: err_cnt saturates at 7 and does not wrap.
- Asynchronous rst_n low mid-RUN: outputs are 0 immediately. A start after release runs cleanly.
- DDR_ERR_INJECT_EN build, err_inject pulsed on 5 RUN samples with a clean stream: err_cnt=5.
